i2c_apb_seq: RTL and testbench
==============================

I2C_APB_SEQ -- requirements
Module: i2c_apb_seq

Interface
REQ-001 Parameter PRESCALE, default 16'd99, is the value programmed into the core clock prescale register at init.
REQ-002 Parameter POLL_MAX, default 16'd65535, is the maximum number of status polls per wait before timeout.
REQ-003 Port apb_pclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port apb_prstn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port req_valid, input, 1 bit: a transaction request is present.
REQ-006 Port req_ready, output, 1 bit: sequencer accepts the request this cycle.
REQ-007 Port req_rw, input, 1 bit: 1 = register read, 0 = register write.
REQ-008 Port req_dev, input, 7 bits: I2C device address.
REQ-009 Port req_reg, input, 8 bits: device register index.
REQ-010 Port req_wdata, input, 8 bits: write data byte.
REQ-011 Port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 Port rsp_rdata, output, 8 bits: read byte; 0 for writes and errors.
REQ-013 Port rsp_err, output, 2 bits: 00 ok, 01 NACK, 10 arbitration lost, 11 timeout.
REQ-014 Ports m_psel, m_penable and m_pwrite, outputs, 1 bit each: APB master controls to the I2C core.
REQ-015 Port m_paddr, output, 3 bits: APB master address to the I2C core.
REQ-016 Port m_pwdata, output, 8 bits: APB master write data.
REQ-017 Port m_prdata, input, 8 bits: I2C core read data.

Function
REQ-018 Every APB access SHALL be two cycles: SETUP (psel=1, penable=0), then ACCESS (psel=1, penable=1); there is no wait state, and m_prdata is sampled at the end of ACCESS.
REQ-019 Consecutive accesses SHALL insert at least one idle cycle with psel=0.
REQ-020 After reset, the block SHALL write, in order, addr 0 = PRESCALE[7:0], addr 1 = PRESCALE[15:8], addr 2 = 8'hA0 (core enable, master mode), then enter IDLE.
REQ-021 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid & req_ready, and all req_* fields are captured at acceptance.
REQ-022 A byte step SHALL consist of: write addr 3 (txr); write addr 4 (cr); hold 2 cycles; poll addr 4 (sr) until sr[1] (tip) = 0; then check status.
REQ-023 Write sequence steps:
 - txr={dev,0}, cr=8'h90
 - txr=reg, cr=8'h10
 - txr=wdata, cr=8'h50
REQ-024 Read sequence steps:
 - txr={dev,0}, cr=8'h90
 - txr=reg, cr=8'h10
 - txr={dev,1}, cr=8'h90
 - cr=8'h68 (stop, read, NACK), with no txr write
 - then read addr 3 into rsp_rdata
REQ-025 Status check after each write step, in priority order:
 - sr[5] (al) = 1 -> error 10, no stop issued
 - else sr[7] (rxack) = 1 -> error 01
REQ-026 On error 01 the block SHALL write cr=8'h40, then poll sr until sr[6] (busy) = 0.
REQ-027 A poll count reaching POLL_MAX SHALL give error 11 with no further APB access; the count resets at each new wait.
REQ-028 States: INIT, IDLE, TXR, CMD, HOLD, POLL, CHECK, RDRX, STOP, STOPW, RESP; a 2-bit step counter SHALL select the byte step.
REQ-029 rsp_valid SHALL pulse for exactly 1 cycle in RESP; the block returns to IDLE the next cycle, and req_ready=1 no earlier than the cycle after rsp_valid.
REQ-030 A req_valid that arrives during INIT or a busy transaction SHALL be held off with no loss and no reordering.

Reset
REQ-031 Asynchronous assertion SHALL force, immediately:
 - m_psel=0, m_penable=0, m_pwrite=0, m_paddr=0, m_pwdata=0
 - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0
 - state INIT
REQ-032 Reset mid-transaction SHALL abandon it with no response, and INIT SHALL rerun after release.
REQ-033 The first APB SETUP SHALL occur on the first clock edge after deassertion.

Verification
REQ-034 Release reset with PRESCALE=99 -> APB writes (0,8'h63), (1,8'h00), (2,8'hA0), then req_ready=1.
REQ-035 Write dev=7'h50, reg=8'h10, data=8'hA5 with the slave ACKing -> txr writes 8'hA0, 8'h10, 8'hA5; cr writes 8'h90, 8'h10, 8'h50; rsp_err=00.
REQ-036 Read dev=7'h50, reg=8'h03 with the slave returning 8'h3C -> txr writes 8'hA0, 8'h03, 8'hA1; cr writes 8'h90, 8'h10, 8'h90, 8'h68; rsp_rdata=8'h3C, rsp_err=00.
REQ-037 Address NACK (sr[7]=1 after step 1) -> cr=8'h40 written, sr[6] polled to 0, rsp_err=01, rsp_rdata=0.
REQ-038 sr[5]=1 after step 2 -> no cr=8'h40 written, rsp_err=10; a bench holding tip=1 with POLL_MAX=4 -> rsp_err=11 after 4 polls.
REQ-039 Reset asserted during a poll -> APB outputs 0 immediately, and INIT writes repeat after release.

Source files
------------

// File: rtl/i2c_apb_seq.sv
// Sequencer that turns single-byte register read/write requests into APB
// accesses on an OpenCores-style I2C master core (init, byte steps, status polling).
module i2c_apb_seq #(
   parameter logic [15:0] PRESCALE = 16'd99,
   parameter logic [15:0] POLL_MAX = 16'd65535
) (
   input  logic       apb_pclk,
   input  logic       apb_prstn,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rw,
   input  logic [6:0] req_dev,
   input  logic [7:0] req_reg,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic [1:0] rsp_err,
   output logic       m_psel,
   output logic       m_penable,
   output logic       m_pwrite,
   output logic [2:0] m_paddr,
   output logic [7:0] m_pwdata,
   input  logic [7:0] m_prdata
);

   typedef enum logic [3:0] {
      S_INIT, S_IDLE, S_TXR, S_CMD, S_HOLD, S_POLL,
      S_CHECK, S_RDRX, S_STOP, S_STOPW, S_RESP
   } state_t;

   // Every access is GAP (psel=0), SETUP, ACCESS; the leading gap gives the idle
   // cycle between back-to-back accesses.
   typedef enum logic [1:0] {PH_GAP, PH_SETUP, PH_ACCESS} phase_t;

   localparam logic [1:0] ERR_NACK = 2'b01;
   localparam logic [1:0] ERR_AL   = 2'b10;
   localparam logic [1:0] ERR_TMO  = 2'b11;

   state_t      state_q, state_d;
   phase_t      phase_q, phase_d;
   logic [1:0]  init_idx_q;
   logic [1:0]  step_q;
   logic        hold_q;
   logic [15:0] poll_cnt_q;
   logic        cap_rw_q;
   logic [6:0]  cap_dev_q;
   logic [7:0]  cap_reg_q;
   logic [7:0]  cap_wdata_q;
   logic        sr_al_q;
   logic        sr_rxack_q;

   logic       apb_state;
   logic       acc_done;
   logic       poll_last;
   logic [7:0] txr_byte;
   logic [7:0] cr_byte;
   logic [7:0] init_byte;

   assign apb_state = (state_q == S_INIT) || (state_q == S_TXR)  || (state_q == S_CMD) ||
                      (state_q == S_POLL) || (state_q == S_RDRX) || (state_q == S_STOP) ||
                      (state_q == S_STOPW);
   assign acc_done  = (phase_q == PH_ACCESS);
   assign poll_last = ({1'b0, poll_cnt_q} + 17'd1) >= {1'b0, POLL_MAX};

   always_ff @(posedge apb_pclk or negedge apb_prstn) begin
      if (!apb_prstn) begin
         state_q <= S_INIT;
         phase_q <= PH_GAP;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // flop samples pre-edge values regardless of process order.
         state_q <= state_d;
         phase_q <= phase_d;
      end
   end

   always_comb begin
      // NOTE: defaults first on every comb output so no path can infer a latch.
      state_d = state_q;
      phase_d = PH_GAP;
      if (apb_state)
         phase_d = (phase_q == PH_ACCESS) ? PH_GAP : phase_t'(phase_q + 2'd1);
      case (state_q)
         S_INIT:  if (acc_done && init_idx_q == 2'd2) state_d = S_IDLE;
         S_IDLE:  if (req_valid) state_d = S_TXR;
         S_TXR:   if (acc_done) state_d = S_CMD;
         S_CMD:   if (acc_done) state_d = S_HOLD;
         S_HOLD:  if (hold_q) state_d = S_POLL;
         S_POLL: begin
            if (acc_done) begin
               if (!m_prdata[1])   state_d = S_CHECK;
               else if (poll_last) state_d = S_RESP;
            end
         end
         S_CHECK: begin
            if (cap_rw_q && step_q == 2'd3)       state_d = S_RDRX;
            else if (sr_al_q)                     state_d = S_RESP;
            else if (sr_rxack_q)                  state_d = S_STOP;
            else if (!cap_rw_q && step_q == 2'd2) state_d = S_RESP;
            else if (cap_rw_q && step_q == 2'd2)  state_d = S_CMD;   // read byte step has no txr write
            else                                  state_d = S_TXR;
         end
         S_RDRX:  if (acc_done) state_d = S_RESP;
         S_STOP:  if (acc_done) state_d = S_STOPW;
         S_STOPW: begin
            if (acc_done && (!m_prdata[6] || poll_last)) state_d = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_INIT;
      endcase
   end

   always_comb begin
      txr_byte = 8'h00;
      cr_byte  = 8'h00;
      case (step_q)
         2'd0: begin txr_byte = {cap_dev_q, 1'b0}; cr_byte = 8'h90; end
         2'd1: begin txr_byte = cap_reg_q;         cr_byte = 8'h10; end
         2'd2: begin
            txr_byte = cap_rw_q ? {cap_dev_q, 1'b1} : cap_wdata_q;
            cr_byte  = cap_rw_q ? 8'h90 : 8'h50;
         end
         default: cr_byte = 8'h68;
      endcase
      case (init_idx_q)
         2'd0:    init_byte = PRESCALE[7:0];
         2'd1:    init_byte = PRESCALE[15:8];
         default: init_byte = 8'hA0;
      endcase
   end

   // APB outputs decode straight from state/phase, so reset clears them at once.
   always_comb begin
      m_psel    = 1'b0;
      m_penable = 1'b0;
      m_pwrite  = 1'b0;
      m_paddr   = 3'd0;
      m_pwdata  = 8'h00;
      if (phase_q != PH_GAP) begin
         m_psel    = 1'b1;
         m_penable = (phase_q == PH_ACCESS);
         case (state_q)
            S_INIT:  begin m_pwrite = 1'b1; m_paddr = {1'b0, init_idx_q}; m_pwdata = init_byte; end
            S_TXR:   begin m_pwrite = 1'b1; m_paddr = 3'd3; m_pwdata = txr_byte; end
            S_CMD:   begin m_pwrite = 1'b1; m_paddr = 3'd4; m_pwdata = cr_byte; end
            S_STOP:  begin m_pwrite = 1'b1; m_paddr = 3'd4; m_pwdata = 8'h40; end
            S_POLL, S_STOPW: m_paddr = 3'd4;
            S_RDRX:  m_paddr = 3'd3;
            default: ;
         endcase
      end
      req_ready = (state_q == S_IDLE);
      rsp_valid = (state_q == S_RESP);
   end

   always_ff @(posedge apb_pclk or negedge apb_prstn) begin
      if (!apb_prstn) begin
         init_idx_q  <= 2'd0;
         step_q      <= 2'd0;
         hold_q      <= 1'b0;
         poll_cnt_q  <= 16'd0;
         cap_rw_q    <= 1'b0;
         cap_dev_q   <= 7'd0;
         cap_reg_q   <= 8'h00;
         cap_wdata_q <= 8'h00;
         sr_al_q     <= 1'b0;
         sr_rxack_q  <= 1'b0;
         rsp_rdata   <= 8'h00;
         rsp_err     <= 2'b00;
      end else begin
         hold_q <= (state_q == S_HOLD);
         if (state_q == S_INIT && acc_done)
            init_idx_q <= init_idx_q + 2'd1;
         if (state_q == S_IDLE && req_valid) begin
            cap_rw_q    <= req_rw;
            cap_dev_q   <= req_dev;
            cap_reg_q   <= req_reg;
            cap_wdata_q <= req_wdata;
            step_q      <= 2'd0;
            rsp_rdata   <= 8'h00;
            rsp_err     <= 2'b00;
         end
         // Poll count restarts whenever a wait state is entered afresh.
         if (state_q != S_POLL && state_q != S_STOPW)
            poll_cnt_q <= 16'd0;
         else if (acc_done)
            poll_cnt_q <= poll_cnt_q + 16'd1;
         if (state_q == S_POLL && acc_done) begin
            sr_al_q    <= m_prdata[5];
            sr_rxack_q <= m_prdata[7];
            if (m_prdata[1] && poll_last) rsp_err <= ERR_TMO;
         end
         if (state_q == S_STOPW && acc_done && m_prdata[6] && poll_last)
            rsp_err <= ERR_TMO;
         if (state_q == S_CHECK && !(cap_rw_q && step_q == 2'd3)) begin
            if (sr_al_q)         rsp_err <= ERR_AL;
            else if (sr_rxack_q) rsp_err <= ERR_NACK;
         end
         if (state_q == S_CHECK && (state_d == S_TXR || state_d == S_CMD))
            step_q <= step_q + 2'd1;
         if (state_q == S_RDRX && acc_done)
            rsp_rdata <= m_prdata;
      end
   end

endmodule

// File: tb/tb_i2c_apb_seq.sv
// Directed bench for i2c_apb_seq with a behavioural I2C core status model on the APB side.
module tb_i2c_apb_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid, req_ready, req_rw;
   logic [6:0] req_dev;
   logic [7:0] req_reg, req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic [1:0] rsp_err;
   logic       m_psel, m_penable, m_pwrite;
   logic [2:0] m_paddr;
   logic [7:0] m_pwdata, m_prdata;

   always #5 clk = ~clk;

   i2c_apb_seq #(.PRESCALE(16'd99), .POLL_MAX(16'd4)) dut (
      .apb_pclk(clk), .apb_prstn(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
      .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata)
   );

   int n_checks = 0;
   int n_fail = 0;

   // Core model knobs and per-transaction logs
   int          tip_n, tip_cnt, busy_cnt, nack_step, al_step, cr_idx;
   bit          tip_stuck, f_rxack, f_al;
   logic [7:0]  rx_byte;
   logic [31:0] txr_seq, cr_seq;
   int          txr_n, cr_n, sr_reads, rx_reads;
   logic [23:0] init_seq;
   logic [5:0]  init_a;
   int          init_n;
   int          gap_viol = 0, proto_viol = 0, rsp_count = 0;
   bit          prev_access, prev_setup;
   bit          got_rsp;
   logic [7:0]  got_rdata;
   logic [1:0]  got_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      txr_seq = 0; cr_seq = 0; txr_n = 0; cr_n = 0; sr_reads = 0; rx_reads = 0;
      cr_idx = 0; f_rxack = 0; f_al = 0; tip_cnt = 0; busy_cnt = 0;
   endtask

   task automatic clear_init();
      init_seq = 0; init_a = 0; init_n = 0;
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_access = 0;
         prev_setup  = 0;
      end else begin
         if (rsp_valid) rsp_count++;
         if (m_penable && !(m_psel && prev_setup)) proto_viol++;
         if (m_psel && !m_penable) begin
            if (prev_access) gap_viol++;
            if (!m_pwrite) begin
               if (m_paddr == 3'd4) begin
                  m_prdata = {f_rxack, busy_cnt != 0, f_al, 3'b000, tip_stuck || tip_cnt != 0, 1'b0};
                  if (tip_cnt != 0) tip_cnt--;
                  if (busy_cnt != 0) busy_cnt--;
               end else begin
                  m_prdata = (m_paddr == 3'd3) ? rx_byte : 8'h00;
               end
            end
         end
         if (m_psel && m_penable) begin
            if (m_pwrite) begin
               if (m_paddr < 3'd3) begin
                  init_seq = {init_seq[15:0], m_pwdata};
                  init_a   = {init_a[3:0], m_paddr[1:0]};
                  init_n++;
               end else if (m_paddr == 3'd3) begin
                  txr_seq = {txr_seq[23:0], m_pwdata};
                  txr_n++;
               end else if (m_paddr == 3'd4) begin
                  cr_seq = {cr_seq[23:0], m_pwdata};
                  cr_n++;
                  if (m_pwdata == 8'h40) busy_cnt = 2;
                  else begin
                     f_rxack = (cr_idx == nack_step);
                     f_al    = (cr_idx == al_step);
                     tip_cnt = tip_n;
                     cr_idx++;
                  end
               end
            end else begin
               if (m_paddr == 3'd4) sr_reads++;
               else if (m_paddr == 3'd3) rx_reads++;
            end
         end
         prev_access = m_psel && m_penable;
         prev_setup  = m_psel && !m_penable;
      end
   end

   task automatic send(input logic rw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
      int  n;
      bit  ready_ok;
      req_rw = rw; req_dev = dev; req_reg = rg; req_wdata = wd; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      ready_ok = req_ready;
      check("req_accepted", {31'b0, ready_ok}, 32'd1);
      clear_log();
      @(posedge clk);
      #1 req_valid = 1'b0;
      got_rsp = 0; got_rdata = 8'hxx; got_err = 2'bxx;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            got_rsp = 1; got_rdata = rsp_rdata; got_err = rsp_err;
            break;
         end
      end
      check("rsp_seen", {31'b0, got_rsp}, 32'd1);
      check("ready_low_in_resp", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      check("rsp_one_cycle", {31'b0, rsp_valid}, 32'd0);
      check("ready_after_resp", {31'b0, req_ready}, 32'd1);
   endtask

   initial begin
      int  n;
      int  rsp_before;
      bit  hit;
      rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_dev = 7'd0; req_reg = 8'h00; req_wdata = 8'h00;
      m_prdata = 8'h00; tip_n = 1; tip_stuck = 0; nack_step = -1; al_step = -1; rx_byte = 8'h00;
      clear_log(); clear_init();

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_apb", {21'b0, m_psel, m_penable, m_pwrite, m_paddr, m_pwdata}, 32'd0);
      check("rst_req_ready", {31'b0, req_ready}, 32'd0);
      check("rst_rsp", {21'b0, rsp_valid, rsp_rdata, rsp_err}, 32'd0);

      // Request pending across INIT must be held off, then served intact
      req_rw = 1'b0; req_dev = 7'h50; req_reg = 8'h10; req_wdata = 8'hA5; req_valid = 1'b1;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("first_setup", {20'b0, m_psel, m_penable, m_pwrite, m_paddr, m_pwdata}, {20'b0, 3'b101, 3'd0, 8'h63});
      check("ready_held_in_init", {31'b0, req_ready}, 32'd0);

      // Write 50/10/A5 with ACKs
      send(1'b0, 7'h50, 8'h10, 8'hA5);
      check("init_data", {8'b0, init_seq}, {8'b0, 24'h6300A0});
      check("init_addr", {26'b0, init_a}, {26'b0, 6'b00_01_10});
      check("init_count", init_n, 3);
      check("wr_txr", txr_seq, 32'h00A010A5);
      check("wr_txr_n", txr_n, 3);
      check("wr_cr", cr_seq, 32'h00901050);
      check("wr_polls", sr_reads, 6);
      check("wr_err", {30'b0, got_err}, 32'd0);
      check("wr_rdata", {24'b0, got_rdata}, 32'd0);

      // Read 50/03 returning 3C
      rx_byte = 8'h3C;
      send(1'b1, 7'h50, 8'h03, 8'h00);
      check("rd_txr", txr_seq, 32'h00A003A1);
      check("rd_txr_n", txr_n, 3);
      check("rd_cr", cr_seq, 32'h90109068);
      check("rd_cr_n", cr_n, 4);
      check("rd_polls", sr_reads, 8);
      check("rd_rx_reads", rx_reads, 1);
      check("rd_rdata", {24'b0, got_rdata}, 32'h3C);
      check("rd_err", {30'b0, got_err}, 32'd0);

      // Address NACK on a read: stop, wait for bus free, rdata cleared
      nack_step = 0;
      send(1'b1, 7'h21, 8'h05, 8'h00);
      check("nack_txr", txr_seq, 32'h00000042);
      check("nack_cr", cr_seq, 32'h00009040);
      check("nack_polls", sr_reads, 5);
      check("nack_rx_reads", rx_reads, 0);
      check("nack_err", {30'b0, got_err}, 32'd1);
      check("nack_rdata", {24'b0, got_rdata}, 32'd0);

      // Arbitration lost after step 2: no stop
      nack_step = -1; al_step = 1;
      send(1'b0, 7'h33, 8'h44, 8'h55);
      check("al_txr", txr_seq, 32'h00006644);
      check("al_cr", cr_seq, 32'h00009010);
      check("al_err", {30'b0, got_err}, 32'd2);

      // AL has priority over NACK
      nack_step = 0; al_step = 0;
      send(1'b0, 7'h0F, 8'h01, 8'h02);
      check("prio_cr", cr_seq, 32'h00000090);
      check("prio_err", {30'b0, got_err}, 32'd2);

      // Stuck tip: timeout after POLL_MAX polls
      nack_step = -1; al_step = -1; tip_stuck = 1;
      send(1'b0, 7'h11, 8'h01, 8'h02);
      check("tmo_polls", sr_reads, 4);
      check("tmo_cr", cr_seq, 32'h00000090);
      check("tmo_txr_n", txr_n, 1);
      check("tmo_err", {30'b0, got_err}, 32'd3);
      repeat (4) @(negedge clk);
      check("tmo_bus_quiet", sr_reads + cr_n + txr_n, 4 + 1 + 1);

      // Reset asserted during a poll
      req_rw = 1'b0; req_dev = 7'h12; req_reg = 8'h34; req_wdata = 8'h56; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      #1 req_valid = 1'b0;
      hit = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (m_psel && !m_penable && !m_pwrite && m_paddr == 3'd4) begin hit = 1; break; end
      end
      check("poll_reached", {31'b0, hit}, 32'd1);
      rsp_before = rsp_count;
      rst_n = 1'b0;
      #1;
      check("midrst_apb", {21'b0, m_psel, m_penable, m_pwrite, m_paddr, m_pwdata}, 32'd0);
      check("midrst_rsp", {20'b0, req_ready, rsp_valid, rsp_rdata, rsp_err}, 32'd0);
      tip_stuck = 0;
      clear_log(); clear_init();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      check("reinit_ready", {31'b0, req_ready}, 32'd1);
      check("reinit_data", {8'b0, init_seq}, {8'b0, 24'h6300A0});
      check("reinit_count", init_n, 3);
      check("reinit_no_rsp", rsp_count, rsp_before);

      check("apb_gap_violations", gap_viol, 0);
      check("apb_protocol_violations", proto_viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
